// File: rtl/led_twinkle.sv
//==============================================================================
// Module   : led_twinkle
// Brief    : Free-running two-LED heartbeat; a terminal-count divider advances
//            a 2-bit pattern (alternate, flash together, or binary count).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module led_twinkle #(
  parameter int CNT_MAX = 24_999_999,
  parameter int PATTERN = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,  // active-high despite the name
  output logic [1:0] led
);

  localparam int              CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // Unsupported selections fold onto the alternate pattern.
  localparam int              PAT_SEL = ((PATTERN == 1) || (PATTERN == 2)) ? PATTERN : 0;
  localparam logic [1:0]      LED_RST = (PAT_SEL == 0) ? 2'b01 : 2'b00;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       led_q;
  logic [1:0]       led_d;
  logic [1:0]       led_step;
  logic             at_tc;

  generate
    if (PAT_SEL == 2) begin : g_step_count
      assign led_step = led_q + 2'd1;
    end else begin : g_step_toggle
      assign led_step = ~led_q;
    end
  endgenerate

  always_comb begin
    at_tc = (cnt_q == CNT_TC);
    cnt_d = at_tc ? '0 : (cnt_q + CNT_ONE);
    led_d = at_tc ? led_step : led_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      cnt_q <= '0;
      led_q <= LED_RST;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

`default_nettype wire

// File: tb/tb_led_twinkle.sv
//==============================================================================
// Module   : tb_led_twinkle
// Brief    : Self-checking bench for led_twinkle against a phase-arithmetic model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_led_twinkle;

  localparam int NI = 5;
  localparam int CMAX [NI] = '{4, 2, 1, 9, 1};
  localparam int PAT  [NI] = '{0, 1, 2, 0, 3};

  logic       clk;
  logic       rst [NI];
  logic [1:0] led [NI];
  int         n_q [NI];  // rising edges with reset low since the last reset edge
  int         total;
  int         bad;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  led_twinkle #(.CNT_MAX(4), .PATTERN(0)) u0 (.sys_clk(clk), .sys_rst_n(rst[0]), .led(led[0]));
  led_twinkle #(.CNT_MAX(2), .PATTERN(1)) u1 (.sys_clk(clk), .sys_rst_n(rst[1]), .led(led[1]));
  led_twinkle #(.CNT_MAX(1), .PATTERN(2)) u2 (.sys_clk(clk), .sys_rst_n(rst[2]), .led(led[2]));
  led_twinkle #(.CNT_MAX(9), .PATTERN(0)) u3 (.sys_clk(clk), .sys_rst_n(rst[3]), .led(led[3]));
  led_twinkle #(.CNT_MAX(1), .PATTERN(3)) u4 (.sys_clk(clk), .sys_rst_n(rst[4]), .led(led[4]));

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) n_q[i] <= rst[i] ? 0 : n_q[i] + 1;
  end

  function automatic logic [1:0] model_led(input int idx, input int n);
    int ph;
    ph = n / (CMAX[idx] + 1);
    case (PAT[idx])
      1:       return (ph % 2 == 1) ? 2'b11 : 2'b00;
      2:       return 2'(ph % 4);
      default: return (ph % 2 == 1) ? 2'b10 : 2'b01;
    endcase
  endfunction

  function automatic logic [31:0] model_cnt(input int idx, input int n);
    return 32'(n % (CMAX[idx] + 1));
  endfunction

  function automatic logic [31:0] get_cnt(input int idx);
    logic [31:0] v;
    v = '0;
    case (idx)
      0: v = {29'b0, u0.cnt_q};
      1: v = {30'b0, u1.cnt_q};
      2: v = {31'b0, u2.cnt_q};
      3: v = {28'b0, u3.cnt_q};
      default: v = {31'b0, u4.cnt_q};
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input int idx, input int edges);
    rst[idx] = 1'b1;
    repeat (edges) tick();
    rst[idx] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (led[0] !== 2'b01 || get_cnt(0) !== 32'd0) begin
        bad++;
        $display("FAIL reset_hold edge=%0d led=%b cnt=%0d expected led=01 cnt=0", k, led[0], get_cnt(0));
      end
    end
    rst[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (led[0] !== ((k < 5) ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL reset_release edge=%0d led=%b expected=%b", k, led[0], (k < 5) ? 2'b01 : 2'b10);
      end
    end
  endtask

  task automatic test_alternate();
    for (int k = 0; k < 30; k++) begin
      tick();
      total++;
      if (led[0] !== model_led(0, n_q[0]) || get_cnt(0) !== model_cnt(0, n_q[0])) begin
        bad++;
        $display("FAIL alternate n=%0d led=%b cnt=%0d expected led=%b cnt=%0d",
                 n_q[0], led[0], get_cnt(0), model_led(0, n_q[0]), model_cnt(0, n_q[0]));
      end
      total++;
      if (led[0] !== 2'b01 && led[0] !== 2'b10) begin
        bad++;
        $display("FAIL alternate_onehot led=%b expected 01 or 10", led[0]);
      end
    end
  endtask

  task automatic test_flash();
    pulse_reset(1, 1);
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (led[1] !== model_led(1, n_q[1]) || get_cnt(1) !== model_cnt(1, n_q[1])) begin
        bad++;
        $display("FAIL flash n=%0d led=%b cnt=%0d expected led=%b cnt=%0d",
                 n_q[1], led[1], get_cnt(1), model_led(1, n_q[1]), model_cnt(1, n_q[1]));
      end
    end
  endtask

  task automatic test_count();
    pulse_reset(2, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (led[2] !== model_led(2, n_q[2]) || get_cnt(2) !== model_cnt(2, n_q[2])) begin
        bad++;
        $display("FAIL count n=%0d led=%b cnt=%0d expected led=%b cnt=%0d",
                 n_q[2], led[2], get_cnt(2), model_led(2, n_q[2]), model_cnt(2, n_q[2]));
      end
    end
  endtask

  task automatic test_midphase_reset();
    pulse_reset(3, 1);
    repeat (16) tick();
    total++;
    if (led[3] !== 2'b10 || get_cnt(3) !== 32'd6) begin
      bad++;
      $display("FAIL midphase_pre led=%b cnt=%0d expected led=10 cnt=6", led[3], get_cnt(3));
    end
    pulse_reset(3, 1);
    total++;
    if (led[3] !== 2'b01 || get_cnt(3) !== 32'd0) begin
      bad++;
      $display("FAIL midphase_reset led=%b cnt=%0d expected led=01 cnt=0", led[3], get_cnt(3));
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if (led[3] !== ((k < 10) ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL midphase_after edge=%0d led=%b expected=%b", k, led[3], (k < 10) ? 2'b01 : 2'b10);
      end
    end
  endtask

  task automatic test_invalid_pattern();
    pulse_reset(4, 1);
    total++;
    if (led[4] !== 2'b01) begin
      bad++;
      $display("FAIL invalid_reset led=%b expected=01", led[4]);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (led[4] !== model_led(4, n_q[4]) || get_cnt(4) !== model_cnt(4, n_q[4])) begin
        bad++;
        $display("FAIL invalid n=%0d led=%b cnt=%0d expected led=%b cnt=%0d",
                 n_q[4], led[4], get_cnt(4), model_led(4, n_q[4]), model_cnt(4, n_q[4]));
      end
    end
  endtask

  task automatic test_random();
    int idx;
    int len;
    for (int it = 0; it < 30; it++) begin
      idx = int'($urandom_range(NI - 1, 0));
      if ($urandom_range(2, 0) == 0) rst[idx] = 1'b1;
      len = int'($urandom_range(25, 1));
      for (int k = 0; k < len; k++) begin
        tick();
        if (k == 0) rst[idx] = 1'b0;
        for (int j = 0; j < NI; j++) begin
          total++;
          if (led[j] !== model_led(j, n_q[j]) || get_cnt(j) !== model_cnt(j, n_q[j])) begin
            bad++;
            $display("FAIL random inst=%0d n=%0d led=%b cnt=%0d expected led=%b cnt=%0d",
                     j, n_q[j], led[j], get_cnt(j), model_led(j, n_q[j]), model_cnt(j, n_q[j]));
          end
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < NI; i++) rst[i] = 1'b1;
    test_reset();
    test_alternate();
    test_flash();
    test_count();
    test_midphase_reset();
    test_invalid_pattern();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_twinkle.md
# led_twinkle

Free-running two-LED blinker for board bring-up and heartbeat indication. It divides the system clock with a parameterised terminal-count counter. On each terminal count it advances a 2-bit LED pattern (alternate, flash together, or binary count). It sits at the top level, driving the board LEDs directly from `sys_clk`, with no other inputs.

## Interface
- `CNT_MAX`, default 24_999_999: terminal count of the divider. One LED phase lasts CNT_MAX+1 clocks (0.5 s at 50 MHz). Must be ≥ 1.
- `PATTERN`, default 0: pattern select.
  - 0 = alternate (01↔10)
  - 1 = flash (00↔11)
  - 2 = binary count (00→01→10→11→00)
  - Any other value behaves as 0.

Ports:
- `sys_clk`, input, 1: system clock. All logic is on the rising edge; there is only one clock.
- `sys_rst_n`, input, 1: synchronous, active-high reset. The name is kept for codebase compatibility; a value of 1 means reset is asserted.
- `led`, output, 2: LED drive, registered output, 1 = LED on.

## Operation
- Internal counter `cnt` has width ceil(log2(CNT_MAX+1)), unsigned.
- Reset, sampled on a rising edge while `sys_rst_n`=1:
  - `cnt` ← 0.
  - `led` ← reset pattern: 2'b01 for PATTERN 0 (and invalid values), 2'b00 for PATTERN 1 and 2.
- Each rising edge with `sys_rst_n`=0:
  - If `cnt` == CNT_MAX: `cnt` ← 0, and `led` advances one step.
  - Otherwise: `cnt` ← `cnt`+1, and `led` holds.
- Pattern step, per PATTERN:
  - PATTERN 0: `led` ← ~`led`, giving 01→10→01. Exactly one LED is lit at all times.
  - PATTERN 1: `led` ← ~`led`, giving 00→11→00.
  - PATTERN 2: `led` ← `led`+1 modulo 4, wrapping from 11 to 00.
- Reset has priority over counting and stepping on the same edge.
- No other state exists. The output is purely a function of `cnt` and `led`, and `led` never glitches because it is driven straight from a flop.
- Before the first reset edge, `led` and `cnt` are undefined (X in simulation). Integration must apply reset at least once.

## Timing
- Reset takes effect on the first rising edge at which `sys_rst_n`=1; `led` shows the reset pattern from that edge onward.
- Reset mid-phase: `cnt` is discarded and `led` returns to the reset pattern on the next edge; there is no partial phase.
- After reset is released, the first `led` change occurs on the (CNT_MAX+1)-th rising edge with `sys_rst_n`=0.
- Every later change occurs exactly CNT_MAX+1 edges after the previous one.
- Full period of the pattern:
  - 2×(CNT_MAX+1) clocks for PATTERN 0 and 1.
  - 4×(CNT_MAX+1) clocks for PATTERN 2.
- Latency from terminal count to `led` update is 0 additional cycles: the same edge that wraps `cnt` updates `led`.
- `cnt` never exceeds CNT_MAX. The wrap from CNT_MAX to 0 is the only non-increment transition.

## Test plan
- **Reset:** CNT_MAX=4, PATTERN=0, 20 ns clock. Hold `sys_rst_n`=1 for 10 edges → `led`=01 and `cnt`=0 throughout. Drop reset → `led` stays 01 for 4 edges and becomes 10 on the 5th edge.
- **Alternate pattern:** CNT_MAX=4, PATTERN=0. Run 30 edges after reset → `led` toggles 01/10 every 5 edges and is never 00 or 11.
- **Flash pattern:** CNT_MAX=2, PATTERN=1. Run after reset → `led` sequence is 00,11,00,11, each held 3 edges.
- **Count pattern with wrap:** CNT_MAX=1, PATTERN=2. Run after reset → `led` goes 00,01,10,11,00 with 2 edges per value, and the 11→00 wrap is correct.
- **Mid-phase reset:** CNT_MAX=9, PATTERN=0. Assert reset for 1 edge when `cnt`=6 and `led`=10 → next edge shows `led`=01 and `cnt`=0. The next toggle occurs 10 edges after reset is released.
- **Invalid PATTERN and minimum CNT_MAX:** PATTERN=3, CNT_MAX=1 → behaves exactly as PATTERN 0: reset value 01, toggling every 2 edges.
